spi_cs_ctrl: RTL and testbench

Parametrised SPI chip-select sequencer, successor to the combinational slave-select decoder. It sits between the SPI master control FSM and the pads. It drives NUM_SS select lines with per-slave polarity, and inserts programmable CS-to-SCK setup, SCK-to-CS hold and inter-transfer idle delays. It gates the shift engine through a registered enable.

---
 rtl/spi_cs_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_spi_cs_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cs_ctrl.sv
// spi_cs_ctrl: SPI chip-select sequencer with per-slave polarity and programmable setup/hold/idle delays.
// Optional macro SPI_CS_KEEP_EN adds input i_keep and a KEEP state that holds CS across transfers.
module spi_cs_ctrl #(
    parameter int                NUM_SS = 4,
    parameter int                SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
    parameter int                DLY_W  = 8,
    parameter logic [NUM_SS-1:0] CS_POL = {NUM_SS{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [SS_W-1:0]   i_ss,
    input  logic [DLY_W-1:0]  i_setup_dly,
    input  logic [DLY_W-1:0]  i_hold_dly,
    input  logic [DLY_W-1:0]  i_idle_dly,
    input  logic              i_done,
`ifdef SPI_CS_KEEP_EN
    input  logic              i_keep,
`endif
    output logic [NUM_SS-1:0] o_ss,
    output logic              o_sck_en,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_err,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACTIVE, S_HOLD, S_GAP
`ifdef SPI_CS_KEEP_EN
        , S_KEEP
`endif
    } state_t;

    // Handshake: i_start is a request taken only while idle (or kept); the block never stalls it,
    // it either accepts (o_ready drops next cycle) or rejects with a one-cycle o_err pulse.
    state_t             state, state_nxt;
    logic [DLY_W-1:0]   cnt, cnt_nxt;
    logic [SS_W-1:0]    ss_r, ss_nxt;
    logic [DLY_W-1:0]   hold_r, hold_nxt, idle_r, idle_nxt;
    logic               err_nxt;
    logic               ss_ok;
    logic               cs_on, rdy;
    logic [NUM_SS-1:0]  ss_dec;
`ifdef SPI_CS_KEEP_EN
    logic               pend, pend_nxt;
    logic [SS_W-1:0]    pend_ss, pend_ss_nxt;
    logic [DLY_W-1:0]   pend_setup, pend_setup_nxt, pend_hold, pend_hold_nxt, pend_idle, pend_idle_nxt;
`endif

    assign ss_ok   = (32'(i_ss) < NUM_SS);
    assign o_state = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ss_nxt    = ss_r;
        hold_nxt  = hold_r;
        idle_nxt  = idle_r;
        err_nxt   = 1'b0;
`ifdef SPI_CS_KEEP_EN
        pend_nxt       = pend;
        pend_ss_nxt    = pend_ss;
        pend_setup_nxt = pend_setup;
        pend_hold_nxt  = pend_hold;
        pend_idle_nxt  = pend_idle;
`endif
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    if (ss_ok) begin
                        state_nxt = S_SETUP;
                        ss_nxt    = i_ss;
                        hold_nxt  = i_hold_dly;
                        idle_nxt  = i_idle_dly;
                        cnt_nxt   = i_setup_dly;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt == '0) state_nxt = S_ACTIVE;
                else           cnt_nxt   = cnt - DLY_W'(1);
            end
            S_ACTIVE: begin
                if (i_done) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = hold_r;
`ifdef SPI_CS_KEEP_EN
                    if (i_keep) state_nxt = S_KEEP;
`endif
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = idle_r;
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
`ifdef SPI_CS_KEEP_EN
                    // A slave switch requested from KEEP resumes here with its own setup.
                    if (pend) begin
                        state_nxt = S_SETUP;
                        ss_nxt    = pend_ss;
                        hold_nxt  = pend_hold;
                        idle_nxt  = pend_idle;
                        cnt_nxt   = pend_setup;
                        pend_nxt  = 1'b0;
                    end
`endif
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                end
            end
`ifdef SPI_CS_KEEP_EN
            S_KEEP: begin
                if (i_start) begin
                    if (!ss_ok) begin
                        err_nxt = 1'b1;
                    end else if (i_ss == ss_r) begin
                        state_nxt = S_ACTIVE;
                        hold_nxt  = i_hold_dly;
                        idle_nxt  = i_idle_dly;
                    end else begin
                        state_nxt      = S_HOLD;
                        cnt_nxt        = hold_r;
                        pend_nxt       = 1'b1;
                        pend_ss_nxt    = i_ss;
                        pend_setup_nxt = i_setup_dly;
                        pend_hold_nxt  = i_hold_dly;
                        pend_idle_nxt  = i_idle_dly;
                    end
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cs_on = (state == S_SETUP) || (state == S_ACTIVE) || (state == S_HOLD);
        rdy   = (state == S_IDLE);
`ifdef SPI_CS_KEEP_EN
        if (state == S_KEEP) begin
            cs_on = 1'b1;
            rdy   = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_SS; k++) begin
            ss_dec[k] = (cs_on && (ss_r == SS_W'(k))) ? CS_POL[k] : ~CS_POL[k];
        end
    end

    // Outputs are registered from the current state, so they trail the state register by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ss_r     <= '0;
            hold_r   <= '0;
            idle_r   <= '0;
            o_ss     <= ~CS_POL;
            o_sck_en <= 1'b0;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_err    <= 1'b0;
`ifdef SPI_CS_KEEP_EN
            pend       <= 1'b0;
            pend_ss    <= '0;
            pend_setup <= '0;
            pend_hold  <= '0;
            pend_idle  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ss_r     <= ss_nxt;
            hold_r   <= hold_nxt;
            idle_r   <= idle_nxt;
            o_ss     <= ss_dec;
            o_sck_en <= (state == S_ACTIVE);
            o_ready  <= rdy;
            o_busy   <= ~rdy;
            o_err    <= err_nxt;
`ifdef SPI_CS_KEEP_EN
            pend       <= pend_nxt;
            pend_ss    <= pend_ss_nxt;
            pend_setup <= pend_setup_nxt;
            pend_hold  <= pend_hold_nxt;
            pend_idle  <= pend_idle_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// Bench for spi_cs_ctrl: timeline reference model driven by random stimulus, plus directed literal checks.
module tb_spi_cs_ctrl;
    localparam int                NUM_SS = 3;
    localparam int                SS_W   = 2;
    localparam int                DLY_W  = 4;
    localparam logic [NUM_SS-1:0] CS_POL = 3'b010;
    localparam int                EXP_W  = NUM_SS + 4;

    logic              clk = 1'b0;
    logic              rst, start, done;
    logic [SS_W-1:0]   ss;
    logic [DLY_W-1:0]  setup_dly, hold_dly, idle_dly;
    logic [NUM_SS-1:0] o_ss;
    logic              sck_en, ready, busy, err;
    logic [2:0]        state_dbg;
`ifdef SPI_CS_KEEP_EN
    logic              keep = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [EXP_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    spi_cs_ctrl #(
        .NUM_SS(NUM_SS), .SS_W(SS_W), .DLY_W(DLY_W), .CS_POL(CS_POL)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_ss(ss),
        .i_setup_dly(setup_dly), .i_hold_dly(hold_dly), .i_idle_dly(idle_dly),
        .i_done(done),
`ifdef SPI_CS_KEEP_EN
        .i_keep(keep),
`endif
        .o_ss(o_ss), .o_sck_en(sck_en), .o_ready(ready), .o_busy(busy),
        .o_err(err), .o_state(state_dbg)
    );

    // Reference model: each transfer is a set of absolute edge numbers at which outputs change.
    int              cyc = 0;
    bit              valid = 1'b0, done_seen = 1'b0;
    int              t_st, sck_on, sck_off, cs_off, ready_at, m_h, m_g;
    int              err_edge = -1;
    logic [SS_W-1:0] m_ss;

    always @(posedge clk) begin
        bit                m_idle, busy_e, cs_e, sck_e, err_e;
        logic [NUM_SS-1:0] ss_e;
        cyc++;
        if (rst) begin
            valid    = 1'b0;
            err_edge = -1;
        end else begin
            m_idle = !valid || (done_seen && cyc >= ready_at);
            if (start && m_idle) begin
                if (int'(ss) < NUM_SS) begin
                    valid     = 1'b1;
                    done_seen = 1'b0;
                    t_st      = cyc;
                    m_ss      = ss;
                    sck_on    = cyc + int'(setup_dly) + 2;
                    m_h       = int'(hold_dly);
                    m_g       = int'(idle_dly);
                end else begin
                    err_edge = cyc;
                end
            end
            if (done && valid && !done_seen && cyc >= sck_on) begin
                done_seen = 1'b1;
                sck_off   = cyc + 1;
                cs_off    = cyc + m_h + 2;
                ready_at  = cs_off + m_g + 1;
            end
        end
        busy_e = valid && cyc >= t_st + 1 && (!done_seen || cyc < ready_at);
        cs_e   = valid && cyc >= t_st + 1 && (!done_seen || cyc < cs_off);
        sck_e  = valid && cyc >= sck_on && (!done_seen || cyc < sck_off);
        err_e  = (err_edge == cyc);
        ss_e   = ~CS_POL;
        if (cs_e) ss_e[m_ss] = CS_POL[m_ss];
        exp_q.push_back({ss_e, sck_e, !busy_e, busy_e, err_e});
    end

    always @(negedge clk) begin
        logic [EXP_W-1:0] exp_v, got_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {o_ss, sck_en, ready, busy, err};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL outputs edge %0d: got ss=%b sck,rdy,busy,err=%b want ss=%b sck,rdy,busy,err=%b",
                         cyc, got_v[EXP_W-1:4], got_v[3:0], exp_v[EXP_W-1:4], exp_v[3:0]);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic logic [DLY_W-1:0] rand_dly();
        return ($urandom_range(0, 7) == 0) ? DLY_W'(15) : DLY_W'($urandom_range(0, 3));
    endfunction

    task automatic launch(input int s, input int su, input int h, input int g);
        start     = 1'b1;
        ss        = SS_W'(s);
        setup_dly = DLY_W'(su);
        hold_dly  = DLY_W'(h);
        idle_dly  = DLY_W'(g);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cs_n, sck_n, gap_n, busy_n, err_n, act_val;
        rst = 1'b1; start = 1'b0; done = 1'b0; ss = '0;
        setup_dly = '0; hold_dly = '0; idle_dly = '0;
        repeat (2) @(negedge clk);
        check("reset_ss", int'(o_ss), 5);
        check("reset_ready", int'(ready), 1);
        check("reset_sck", int'(sck_en), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;

        // Slave 1, setup 2, hold 1, idle 3, done after five SCK-enabled cycles.
        launch(1, 2, 1, 3);
        ss = 2'd2; setup_dly = 4'd9; hold_dly = 4'd9; idle_dly = 4'd9;
        cs_n = 0; sck_n = 0; gap_n = 0; act_val = 0;
        for (int c = 0; c < 30; c++) begin
            if (o_ss != ~CS_POL) begin cs_n++; act_val = int'(o_ss); end
            if (sck_en) sck_n++;
            if (cs_n > 0 && o_ss == ~CS_POL && busy) gap_n++;
            done = sck_en && (sck_n == 4);
            @(negedge clk);
        end
        done = 1'b0;
        check("a_cs_cycles", cs_n, 10);
        check("a_sck_cycles", sck_n, 5);
        check("a_gap_cycles", gap_n, 4);
        check("a_active_ss", act_val, 7);
        check("a_ready_end", int'(ready), 1);

        // All delays zero, done already high in the first ACTIVE cycle.
        done = 1'b1;
        launch(0, 0, 0, 0);
        busy_n = 0; sck_n = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy) busy_n++;
            if (sck_en) sck_n++;
            @(negedge clk);
        end
        check("min_busy_cycles", busy_n, 4);
        check("min_sck_cycles", sck_n, 1);

        // Maximum setup and hold: 16 cycles each with no counter wrap.
        launch(2, 15, 15, 0);
        cs_n = 0; sck_n = 0; busy_n = 0; act_val = 0;
        for (int c = 0; c < 50; c++) begin
            if (o_ss != ~CS_POL) begin cs_n++; act_val = int'(o_ss); end
            if (sck_en) sck_n++;
            if (busy) busy_n++;
            @(negedge clk);
        end
        done = 1'b0;
        check("max_cs_cycles", cs_n, 33);
        check("max_sck_cycles", sck_n, 1);
        check("max_busy_cycles", busy_n, 34);
        check("max_active_ss", act_val, 1);

        // Out-of-range slave index is rejected.
        launch(3, 1, 1, 1);
        err_n = 0; busy_n = 0; cs_n = 0;
        for (int c = 0; c < 5; c++) begin
            if (err) err_n++;
            if (busy) busy_n++;
            if (o_ss != ~CS_POL) cs_n++;
            @(negedge clk);
        end
        check("err_pulses", err_n, 1);
        check("err_busy", busy_n, 0);
        check("err_cs", cs_n, 0);

        // Reset while ACTIVE releases CS immediately; a later done is ignored.
        launch(2, 0, 3, 3);
        for (int c = 0; c < 20 && !sck_en; c++) @(negedge clk);
        check("rst_reached_active", int'(sck_en), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ss", int'(o_ss), 5);
        check("rst_sck", int'(sck_en), 0);
        check("rst_ready", int'(ready), 1);
        done = 1'b1;
        busy_n = 0; cs_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (o_ss != ~CS_POL) cs_n++;
        end
        done = 1'b0;
        check("rst_done_ignored_busy", busy_n, 0);
        check("rst_done_ignored_cs", cs_n, 0);

        // Random traffic: requests, done and reset arrive in any state.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 2) == 0);
            ss        = SS_W'($urandom_range(0, 3));
            setup_dly = rand_dly();
            hold_dly  = rand_dly();
            idle_dly  = rand_dly();
            done      = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; done = 1'b1;
        repeat (80) @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
